// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage: registers the EX-stage instruction, extracts
// and extends load data from the data-SRAM read word, and presents the final
// register write to WB under a valid/ready handshake.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   ex_to_mem_valid / o_mem_ready      EX->MEM handshake
//   mem_to_wb_valid / i_wb_ready       MEM->WB handshake
//   ex_to_mem_mem_signal        load sign-extend (1) / zero-extend (0)
//   ex_to_mem_mem_re [3:0]      load byte-lane mask, 0 = not a load
//   ex_to_mem_alu_res/pc/inst   32-bit ALU result, PC, instruction word
//   ex_to_mem_rf_waddr/rf_we    destination register and write enable
//   dsram_rdata [31:0]          SRAM read data, valid the cycle the load is in MEM
//   mem_to_wb_rf_wdata/waddr/we, mem_to_wb_pc/inst   WB-side outputs
//   memu_active                 stage holds a valid instruction
//
// Optional feature (macro MEM_BYPASS_EN): adds mem_fwd_valid/waddr/wdata,
// the MEM-stage register write exposed for ID-stage forwarding.
// ---------------------------------------------------------------------------
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_to_mem_valid,
   output logic        o_mem_ready,
   input  logic        i_wb_ready,
   output logic        mem_to_wb_valid,
   input  logic        ex_to_mem_mem_signal,
   input  logic [3:0]  ex_to_mem_mem_re,
   input  logic [31:0] ex_to_mem_alu_res,
   input  logic [31:0] ex_to_mem_pc,
   input  logic [31:0] ex_to_mem_inst,
   input  logic [4:0]  ex_to_mem_rf_waddr,
   input  logic        ex_to_mem_rf_we,
   input  logic [31:0] dsram_rdata,
   output logic [31:0] mem_to_wb_rf_wdata,
   output logic [4:0]  mem_to_wb_rf_waddr,
   output logic        mem_to_wb_rf_we,
   output logic [31:0] mem_to_wb_pc,
   output logic [31:0] mem_to_wb_inst,
   output logic        memu_active
`ifdef MEM_BYPASS_EN
   ,
   output logic        mem_fwd_valid,
   output logic [4:0]  mem_fwd_waddr,
   output logic [31:0] mem_fwd_wdata
`endif
);

   typedef enum logic [1:0] {
      LD_EMPTY = 2'd0,
      LD_LIVE  = 2'd1,
      LD_HELD  = 2'd2
   } ld_state_e;

   ld_state_e   state_q, state_d;
   logic        mem_valid_q;
   logic        signal_q;
   logic [3:0]  re_q;
   logic [31:0] alu_q, pc_q, inst_q;
   logic [4:0]  waddr_q;
   logic        we_q;
   logic [31:0] hold_q, hold_d;

   logic        accept;
   logic        is_load_in;
   logic [31:0] live_ext;
   logic [31:0] load_data;
   logic [15:0] field16;
   logic [7:0]  field8;
   logic [1:0]  fsize;   // 0: word/none, 1: halfword, 2: byte

   assign o_mem_ready = !mem_valid_q | i_wb_ready;
   assign accept      = ex_to_mem_valid & o_mem_ready;
   assign is_load_in  = (ex_to_mem_mem_re != 4'b0000);

   // ---------------------------------------------------------------- stage regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid_q <= 1'b0;
         signal_q    <= 1'b0;
         re_q        <= '0;
         alu_q       <= '0;
         pc_q        <= '0;
         inst_q      <= '0;
         waddr_q     <= '0;
         we_q        <= 1'b0;
      end else begin
         if (accept) begin
            mem_valid_q <= 1'b1;
            signal_q    <= ex_to_mem_mem_signal;
            re_q        <= ex_to_mem_mem_re;
            alu_q       <= ex_to_mem_alu_res;
            pc_q        <= ex_to_mem_pc;
            inst_q      <= ex_to_mem_inst;
            waddr_q     <= ex_to_mem_rf_waddr;
            we_q        <= ex_to_mem_rf_we;
         end else if (mem_valid_q & i_wb_ready) begin
            mem_valid_q <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------- lane extraction
   always_comb begin
      live_ext = '0;
      field16  = '0;
      field8   = '0;
      fsize    = 2'd0;
      case (re_q)
         4'b1111: live_ext = dsram_rdata;
         4'b0011: begin field16 = dsram_rdata[15:0];  fsize = 2'd1; end
         4'b0110: begin field16 = dsram_rdata[23:8];  fsize = 2'd1; end
         4'b1100: begin field16 = dsram_rdata[31:16]; fsize = 2'd1; end
         4'b0001: begin field8  = dsram_rdata[7:0];   fsize = 2'd2; end
         4'b0010: begin field8  = dsram_rdata[15:8];  fsize = 2'd2; end
         4'b0100: begin field8  = dsram_rdata[23:16]; fsize = 2'd2; end
         4'b1000: begin field8  = dsram_rdata[31:24]; fsize = 2'd2; end
         default: live_ext = '0;
      endcase
      if (fsize == 2'd1)
         live_ext = {{16{signal_q & field16[15]}}, field16};
      else if (fsize == 2'd2)
         live_ext = {{24{signal_q & field8[7]}}, field8};
   end

   // ------------------------------------------------------- load-data FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LD_EMPTY;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         LD_EMPTY: begin
            if (accept & is_load_in) state_d = LD_LIVE;
         end
         LD_LIVE, LD_HELD: begin
            if (i_wb_ready) begin
               state_d = (accept & is_load_in) ? LD_LIVE : LD_EMPTY;
            end else if (state_q == LD_LIVE) begin
               // SRAM data is only valid for one cycle; capture it before WB stalls past it
               state_d = LD_HELD;
               hold_d  = live_ext;
            end
         end
         default: state_d = LD_EMPTY;
      endcase
   end

   assign load_data = (state_q == LD_HELD) ? hold_q : live_ext;

   // ------------------------------------------------------- outputs
   assign mem_to_wb_valid    = mem_valid_q;
   assign memu_active        = mem_valid_q;
   assign mem_to_wb_rf_wdata = (re_q != 4'b0000) ? load_data : alu_q;
   assign mem_to_wb_rf_waddr = waddr_q;
   assign mem_to_wb_rf_we    = mem_valid_q & we_q;
   assign mem_to_wb_pc       = pc_q;
   assign mem_to_wb_inst     = inst_q;

`ifdef MEM_BYPASS_EN
   assign mem_fwd_valid = mem_valid_q & we_q;
   assign mem_fwd_waddr = waddr_q;
   assign mem_fwd_wdata = mem_to_wb_rf_wdata;
`endif

endmodule
